// File: rtl/filter_pkg.sv
// ---------------------------------------------------------------------------
// filter_pkg -- shared types and constants for the pump control path.
//
// Contents:
//   arb_state_t  ramp-grant arbiter states (IDLE, RAMP_A, RAMP_B)
//   DUTY_W       width of every duty value
//   PWM_MAX/MIN  PWM duty operating limits used by the filter FSM
//   sat_step()   saturating duty increment, clipped to the target
// ---------------------------------------------------------------------------
package filter_pkg;

  localparam int unsigned DUTY_W = 8;

  localparam logic [DUTY_W-1:0] PWM_MAX = 8'd230;
  localparam logic [DUTY_W-1:0] PWM_MIN = 8'd77;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP_A = 2'd1,
    RAMP_B = 2'd2
  } arb_state_t;

  // Sum is formed 9 bits wide so a step near 255 cannot wrap before the
  // comparison against the target.
  function automatic logic [DUTY_W-1:0] sat_step(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] step,
    input logic [DUTY_W-1:0] target
  );
    logic [DUTY_W:0] sum;
    sum = {1'b0, duty} + {1'b0, step};
    if (sum > {1'b0, target}) begin
      sat_step = target;
    end else begin
      sat_step = sum[DUTY_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pump_ramp_channel.sv
// ---------------------------------------------------------------------------
// pump_ramp_channel -- one pump channel: applied-duty register, step timer
// and (optionally) the minimum-off lockout counter.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   target       requested duty
//   estop        synchronous emergency stop (forces duty to 0)
//   grant        channel currently holds the ramp grant
//   duty         applied duty (registered)
//   locked       min-off lockout active (registered, 0 when feature off)
//
// Build option: PUMP_MIN_OFF_EN enables the min-off lockout counter.
// ---------------------------------------------------------------------------
module pump_ramp_channel
  import filter_pkg::*;
#(
  parameter int unsigned       RAMP_STEP_CYCLES = 500_000,
  parameter logic [DUTY_W-1:0] RAMP_STEP        = 8'd5,
  parameter int unsigned       MIN_OFF_CYCLES   = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] target,
  input  logic              estop,
  input  logic              grant,
  output logic [DUTY_W-1:0] duty,
  output logic              locked
);

  localparam logic [31:0] STEP_LAST_C = 32'(RAMP_STEP_CYCLES - 1);

  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_next_s;
  logic [31:0]       timer_r;
  logic              step_due_s;

  assign step_due_s = (timer_r == STEP_LAST_C);

  // Next applied duty: estop beats a decrease, a decrease beats a ramp step.
  always_comb begin
    duty_next_s = duty_r;
    if (estop) begin
      duty_next_s = 8'd0;
    end else if (target < duty_r) begin
      duty_next_s = target;
    end else if (grant && step_due_s && (target > duty_r)) begin
      duty_next_s = sat_step(duty_r, RAMP_STEP, target);
    end else begin
      duty_next_s = duty_r;
    end
  end

  // Applied duty register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_r <= 8'd0;
    end else begin
      duty_r <= duty_next_s;
    end
  end

  // Step timer: held at 0 outside a grant, so it starts fresh on each grant
  // entry but keeps running if the target moves up during the ramp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_r <= 32'd0;
    end else if (!grant || estop) begin
      timer_r <= 32'd0;
    end else if (step_due_s) begin
      timer_r <= 32'd0;
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

  assign duty = duty_r;

`ifdef PUMP_MIN_OFF_EN
  logic        locked_r;
  logic [31:0] lock_cnt_r;

  // Min-off lockout: armed on a nonzero-to-zero duty change, held for
  // MIN_OFF_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_r   <= 1'b0;
      lock_cnt_r <= 32'd0;
    end else if ((duty_r != 8'd0) && (duty_next_s == 8'd0)) begin
      locked_r   <= 1'b1;
      lock_cnt_r <= 32'(MIN_OFF_CYCLES - 1);
    end else if (locked_r) begin
      if (lock_cnt_r == 32'd0) begin
        locked_r <= 1'b0;
      end else begin
        lock_cnt_r <= lock_cnt_r - 32'd1;
      end
    end else begin
      locked_r <= 1'b0;
    end
  end

  assign locked = locked_r;
`else
  logic unused_min_off_s;
  assign unused_min_off_s = ^(32'(MIN_OFF_CYCLES));
  assign locked = 1'b0;
`endif

endmodule

// File: rtl/pump_ramp_scheduler.sv
// ---------------------------------------------------------------------------
// pump_ramp_scheduler -- soft-start scheduler for two pumps. Only one
// channel may raise its duty at a time; decreases and estop act at once.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   target_duty_a/_b [7:0]     requested duties from the filter FSM
//   estop                      synchronous level-sensitive emergency stop
//   duty_a/_b [7:0]            applied duties for the PWM generators
//   ramping_a/_b               channel holds the ramp grant
//   locked_a/_b                min-off lockout active
//
// Build option: PUMP_MIN_OFF_EN enables the per-channel min-off lockout.
// ---------------------------------------------------------------------------
module pump_ramp_scheduler
  import filter_pkg::*;
#(
  parameter int unsigned       RAMP_STEP_CYCLES = 500_000,
  parameter logic [DUTY_W-1:0] RAMP_STEP        = 8'd5,
  parameter int unsigned       MIN_OFF_CYCLES   = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] target_duty_a,
  input  logic [DUTY_W-1:0] target_duty_b,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty_a,
  output logic [DUTY_W-1:0] duty_b,
  output logic              ramping_a,
  output logic              ramping_b,
  output logic              locked_a,
  output logic              locked_b
);

  arb_state_t state_r;
  arb_state_t state_next_s;
  logic       last_b_r;        // 1: channel B was granted most recently
  logic       last_b_next_s;
  logic       ramping_a_r;
  logic       ramping_b_r;
  logic       req_a_s;
  logic       req_b_s;

  assign req_a_s = !estop && !locked_a && (target_duty_a > duty_a);
  assign req_b_s = !estop && !locked_b && (target_duty_b > duty_b);

  pump_ramp_channel #(
    .RAMP_STEP_CYCLES (RAMP_STEP_CYCLES),
    .RAMP_STEP        (RAMP_STEP),
    .MIN_OFF_CYCLES   (MIN_OFF_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .reset  (reset),
    .target (target_duty_a),
    .estop  (estop),
    .grant  (state_r == RAMP_A),
    .duty   (duty_a),
    .locked (locked_a)
  );

  pump_ramp_channel #(
    .RAMP_STEP_CYCLES (RAMP_STEP_CYCLES),
    .RAMP_STEP        (RAMP_STEP),
    .MIN_OFF_CYCLES   (MIN_OFF_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .reset  (reset),
    .target (target_duty_b),
    .estop  (estop),
    .grant  (state_r == RAMP_B),
    .duty   (duty_b),
    .locked (locked_b)
  );

  // Arbiter next state. A grant ends when the target is reached or lowered
  // (same cycle the decrease is seen); the other channel then waits one IDLE
  // cycle before its grant.
  always_comb begin
    state_next_s  = state_r;
    last_b_next_s = last_b_r;
    case (state_r)
      IDLE: begin
        if (req_a_s && req_b_s) begin
          state_next_s  = last_b_r ? RAMP_A : RAMP_B;
          last_b_next_s = !last_b_r;
        end else if (req_a_s) begin
          state_next_s  = RAMP_A;
          last_b_next_s = 1'b0;
        end else if (req_b_s) begin
          state_next_s  = RAMP_B;
          last_b_next_s = 1'b1;
        end else begin
          state_next_s  = IDLE;
        end
      end
      RAMP_A: begin
        if (estop || (target_duty_a <= duty_a)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RAMP_A;
        end
      end
      RAMP_B: begin
        if (estop || (target_duty_b <= duty_b)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RAMP_B;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Arbiter state, fairness bit and registered grant flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      last_b_r    <= 1'b1;
      ramping_a_r <= 1'b0;
      ramping_b_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      last_b_r    <= last_b_next_s;
      ramping_a_r <= (state_next_s == RAMP_A);
      ramping_b_r <= (state_next_s == RAMP_B);
    end
  end

  assign ramping_a = ramping_a_r;
  assign ramping_b = ramping_b_r;

endmodule

// File: tb/tb_pump_ramp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pump_ramp_scheduler -- directed self-checking bench for
// pump_ramp_scheduler with RAMP_STEP_CYCLES=4, RAMP_STEP=5,
// MIN_OFF_CYCLES=10. Expectations follow PUMP_MIN_OFF_EN when defined.
// ---------------------------------------------------------------------------
module tb_pump_ramp_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] target_duty_a;
  logic [7:0] target_duty_b;
  logic       estop;
  logic [7:0] duty_a;
  logic [7:0] duty_b;
  logic       ramping_a;
  logic       ramping_b;
  logic       locked_a;
  logic       locked_b;

  int checks = 0;
  int errors = 0;
  int both_hi = 0;

  pump_ramp_scheduler #(
    .RAMP_STEP_CYCLES (4),
    .RAMP_STEP        (8'd5),
    .MIN_OFF_CYCLES   (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .target_duty_a (target_duty_a),
    .target_duty_b (target_duty_b),
    .estop         (estop),
    .duty_a        (duty_a),
    .duty_b        (duty_b),
    .ramping_a     (ramping_a),
    .ramping_b     (ramping_b),
    .locked_a      (locked_a),
    .locked_b      (locked_b)
  );

  always #5 clk = ~clk;

  // Grant exclusivity monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (ramping_a && ramping_b) both_hi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    target_duty_a = 8'd0;
    target_duty_b = 8'd0;
    estop = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    target_duty_a = 8'd0;
    target_duty_b = 8'd0;
    estop = 1'b0;
    tick(2);
    check("rst_duty_a", 32'(duty_a), 32'd0);
    check("rst_duty_b", 32'(duty_b), 32'd0);
    check("rst_ramp_a", 32'(ramping_a), 32'd0);
    check("rst_ramp_b", 32'(ramping_b), 32'd0);
    check("rst_lock_a", 32'(locked_a), 32'd0);
    check("rst_lock_b", 32'(locked_b), 32'd0);
    reset = 1'b0;

    // Basic ramp 0 -> 20 at 4-cycle spacing.
    target_duty_a = 8'd20;
    tick(1);
    check("t1_grant", 32'(ramping_a), 32'd1);
    tick(3);
    check("t1_d0", 32'(duty_a), 32'd0);
    tick(1);
    check("t1_d5", 32'(duty_a), 32'd5);
    tick(4);
    check("t1_d10", 32'(duty_a), 32'd10);
    tick(4);
    check("t1_d15", 32'(duty_a), 32'd15);
    tick(4);
    check("t1_d20", 32'(duty_a), 32'd20);
    check("t1_still_ramp", 32'(ramping_a), 32'd1);
    tick(1);
    check("t1_release", 32'(ramping_a), 32'd0);
    check("t1_hold", 32'(duty_a), 32'd20);

    // Simultaneous requests after reset: A first, then B.
    do_reset();
    target_duty_a = 8'd10;
    target_duty_b = 8'd10;
    tick(1);
    check("t2_a_first", 32'(ramping_a), 32'd1);
    check("t2_b_wait", 32'(ramping_b), 32'd0);
    tick(8);
    check("t2_a_10", 32'(duty_a), 32'd10);
    check("t2_b_0", 32'(duty_b), 32'd0);
    tick(1);
    check("t2_idle_a", 32'(ramping_a), 32'd0);
    check("t2_idle_b", 32'(ramping_b), 32'd0);
    tick(1);
    check("t2_b_grant", 32'(ramping_b), 32'd1);
    tick(8);
    check("t2_b_10", 32'(duty_b), 32'd10);
    tick(1);
    check("t2_b_release", 32'(ramping_b), 32'd0);

    // Decrease mid-ramp releases the grant and serves B.
    do_reset();
    target_duty_a = 8'd40;
    target_duty_b = 8'd10;
    tick(1);
    check("t3_a_grant", 32'(ramping_a), 32'd1);
    tick(12);
    check("t3_a_15", 32'(duty_a), 32'd15);
    target_duty_a = 8'd7;
    tick(1);
    check("t3_a_7", 32'(duty_a), 32'd7);
    check("t3_a_release", 32'(ramping_a), 32'd0);
    tick(1);
    check("t3_b_grant", 32'(ramping_b), 32'd1);
    check("t3_a_noreq", 32'(ramping_a), 32'd0);
    tick(4);
    check("t3_b_5", 32'(duty_b), 32'd5);
    check("t3_a_hold", 32'(duty_a), 32'd7);

    // Estop with A at 230 and B ramping.
    do_reset();
    target_duty_a = 8'd230;
    tick(1);
    tick(184);
    check("t4_a_230", 32'(duty_a), 32'd230);
    tick(1);
    check("t4_a_release", 32'(ramping_a), 32'd0);
    target_duty_b = 8'd100;
    tick(1);
    check("t4_b_grant", 32'(ramping_b), 32'd1);
    tick(8);
    check("t4_b_10", 32'(duty_b), 32'd10);
    estop = 1'b1;
    tick(1);
    check("t4_es_a0", 32'(duty_a), 32'd0);
    check("t4_es_b0", 32'(duty_b), 32'd0);
    check("t4_es_idle", 32'(ramping_b), 32'd0);
    tick(2);
    check("t4_es_block", 32'({ramping_a, ramping_b}), 32'd0);
    check("t4_es_hold_a", 32'(duty_a), 32'd0);
    estop = 1'b0;
`ifdef PUMP_MIN_OFF_EN
    tick(1);
    check("t4_lock_a", 32'(locked_a), 32'd1);
    check("t4_lock_nogrant", 32'(ramping_a), 32'd0);
    tick(7);
    check("t4_unlock_a", 32'(locked_a), 32'd0);
    check("t4_unlock_nogrant", 32'(ramping_a), 32'd0);
    tick(1);
    check("t4_resume_grant", 32'(ramping_a), 32'd1);
    tick(4);
    check("t4_resume_5", 32'(duty_a), 32'd5);
`else
    tick(1);
    check("t4_resume_grant", 32'(ramping_a), 32'd1);
    check("t4_resume_b_wait", 32'(ramping_b), 32'd0);
    tick(4);
    check("t4_resume_5", 32'(duty_a), 32'd5);
    check("t4_b_still0", 32'(duty_b), 32'd0);
`endif

    // Min-off lockout on 50 -> 0 -> 50.
    do_reset();
    target_duty_a = 8'd50;
    tick(1);
    tick(40);
    check("t5_a_50", 32'(duty_a), 32'd50);
    tick(1);
    check("t5_a_release", 32'(ramping_a), 32'd0);
    target_duty_a = 8'd0;
    tick(1);
    check("t5_a_0", 32'(duty_a), 32'd0);
    target_duty_a = 8'd50;
`ifdef PUMP_MIN_OFF_EN
    check("t5_locked", 32'(locked_a), 32'd1);
    tick(9);
    check("t5_locked_last", 32'(locked_a), 32'd1);
    check("t5_no_grant", 32'(ramping_a), 32'd0);
    tick(1);
    check("t5_unlocked", 32'(locked_a), 32'd0);
    check("t5_no_grant_yet", 32'(ramping_a), 32'd0);
    tick(1);
    check("t5_grant", 32'(ramping_a), 32'd1);
`else
    check("t5_nolock", 32'(locked_a), 32'd0);
    tick(1);
    check("t5_grant", 32'(ramping_a), 32'd1);
`endif

    // Target raised mid-ramp, then reset mid-ramp at duty_b = 120.
    do_reset();
    target_duty_b = 8'd120;
    tick(1);
    check("t6_b_grant", 32'(ramping_b), 32'd1);
    tick(92);
    check("t6_b_115", 32'(duty_b), 32'd115);
    target_duty_b = 8'd200;
    tick(4);
    check("t6_b_120", 32'(duty_b), 32'd120);
    check("t6_b_ramping", 32'(ramping_b), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_duty_b", 32'(duty_b), 32'd0);
    check("t6_rst_ramp_b", 32'(ramping_b), 32'd0);
    check("t6_rst_duty_a", 32'(duty_a), 32'd0);
    check("t6_rst_locks", 32'({locked_a, locked_b, ramping_a}), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("t6_regrant", 32'(ramping_b), 32'd1);
    check("t6_restart0", 32'(duty_b), 32'd0);
    tick(4);
    check("t6_restart5", 32'(duty_b), 32'd5);

    check("mutex", 32'(both_hi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
